// File: rtl/uart_cmd_decoder.sv
// rtl/uart_cmd_decoder.sv - assembles UART command frames into wide pattern/period registers
module uart_cmd_decoder #(
  parameter int DATA_BIT = 32,
  parameter int PACK_NUM = 5,
  parameter int FREQ_NUM = 6
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [7:0]          data_i,
  input  logic                rx_done_tick_i,
  output logic [DATA_BIT-1:0] output_pattern_o,
  output logic [DATA_BIT-1:0] freq_pattern_o,
  output logic [3:0]          sel_out_o,
  output logic                mode_o,
  output logic                start_o,
  output logic                stop_o,
  output logic [7:0]          slow_period_o,
  output logic [7:0]          fast_period_o,
  output logic [7:0]          cmd_o,
  output logic                done_tick_o
);

  localparam int NB    = DATA_BIT / 8;
  // The shadow buffer is sized for the longer of the two frame types.
  localparam int BUF_N = (PACK_NUM > FREQ_NUM) ? PACK_NUM : FREQ_NUM;
  localparam int CW    = (BUF_N > 1) ? $clog2(BUF_N) : 1;

  localparam logic [CW-1:0] PACK_LAST = CW'(PACK_NUM - 1);
  localparam logic [CW-1:0] FREQ_LAST = CW'(FREQ_NUM - 1);
  localparam logic [7:0]    CMD_FREQ  = 8'h0A;
  localparam logic [7:0]    CMD_DATA  = 8'h0B;

  typedef enum logic [1:0] {IDLE, DATA, FREQ, DONE} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [8*BUF_N-1:0]  shadow;
  logic [7:0]          cmd_q;

  // Control byte bit 3 is reserved; it is captured but never published.
  logic ctrl_rsvd_unused;
  assign ctrl_rsvd_unused = shadow[8*NB+3];

  // Frame collection into the shadow buffer; outputs update only in DONE so a
  // frame is published atomically.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state            <= IDLE;
      cnt              <= '0;
      shadow           <= '0;
      cmd_q            <= '0;
      output_pattern_o <= '0;
      freq_pattern_o   <= '0;
      sel_out_o        <= '0;
      mode_o           <= 1'b0;
      start_o          <= 1'b0;
      stop_o           <= 1'b0;
      slow_period_o    <= '0;
      fast_period_o    <= '0;
      cmd_o            <= '0;
      done_tick_o      <= 1'b0;
    end else begin
      done_tick_o <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_done_tick_i) begin
            if (data_i == CMD_DATA) begin
              state <= DATA;
              cnt   <= '0;
              cmd_q <= data_i;
            end else if (data_i == CMD_FREQ) begin
              state <= FREQ;
              cnt   <= '0;
              cmd_q <= data_i;
            end
          end
        end
        DATA: begin
          if (rx_done_tick_i) begin
            shadow[8*cnt +: 8] <= data_i;
            if (cnt == PACK_LAST) state <= DONE;
            else                  cnt   <= cnt + 1'b1;
          end
        end
        FREQ: begin
          if (rx_done_tick_i) begin
            shadow[8*cnt +: 8] <= data_i;
            if (cnt == FREQ_LAST) state <= DONE;
            else                  cnt   <= cnt + 1'b1;
          end
        end
        DONE: begin
          // Any strobe landing in this cycle is intentionally dropped.
          done_tick_o <= 1'b1;
          cmd_o       <= cmd_q;
          if (cmd_q == CMD_DATA) begin
            output_pattern_o <= shadow[DATA_BIT-1:0];
            sel_out_o        <= shadow[8*NB+4 +: 4];
            mode_o           <= shadow[8*NB+2];
            stop_o           <= shadow[8*NB+1];
            start_o          <= shadow[8*NB];
          end else begin
            freq_pattern_o   <= shadow[DATA_BIT-1:0];
            slow_period_o    <= shadow[8*NB +: 8];
            fast_period_o    <= shadow[8*(NB+1) +: 8];
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb/tb_uart_cmd_decoder.sv - randomized self-checking bench for uart_cmd_decoder
module tb_uart_cmd_decoder;

  localparam int NB = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [7:0]  data_i;
  logic        rx_done_tick_i;
  logic [31:0] output_pattern_o, freq_pattern_o;
  logic [3:0]  sel_out_o;
  logic        mode_o, start_o, stop_o, done_tick_o;
  logic [7:0]  slow_period_o, fast_period_o, cmd_o;

  uart_cmd_decoder dut (
    .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .rx_done_tick_i(rx_done_tick_i),
    .output_pattern_o(output_pattern_o), .freq_pattern_o(freq_pattern_o),
    .sel_out_o(sel_out_o), .mode_o(mode_o), .start_o(start_o), .stop_o(stop_o),
    .slow_period_o(slow_period_o), .fast_period_o(fast_period_o),
    .cmd_o(cmd_o), .done_tick_o(done_tick_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int last_strobe_cyc = 0;

  // Reference state: what the published registers should hold.
  logic [31:0] e_out, e_freq;
  logic [3:0]  e_sel;
  logic        e_mode, e_start, e_stop;
  logic [7:0]  e_slow, e_fast, e_cmd;

  logic [7:0] frame_q[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (done_tick_o === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  function automatic logic [94:0] obs();
    return {output_pattern_o, freq_pattern_o, sel_out_o, mode_o, start_o, stop_o,
            slow_period_o, fast_period_o, cmd_o};
  endfunction

  function automatic logic [94:0] expv();
    return {e_out, e_freq, e_sel, e_mode, e_start, e_stop, e_slow, e_fast, e_cmd};
  endfunction

  task automatic model_clear();
    e_out = '0; e_freq = '0; e_sel = '0; e_mode = 0; e_start = 0; e_stop = 0;
    e_slow = '0; e_fast = '0; e_cmd = '0;
  endtask

  // Frame-level model: pattern bytes little-endian, then the trailing fields.
  task automatic model_apply();
    logic [31:0] pat;
    logic [7:0]  ctrl;
    pat = 0;
    for (int i = 0; i < NB; i++) pat = pat | (32'(frame_q[1+i]) << (8*i));
    e_cmd = frame_q[0];
    if (frame_q[0] == 8'h0A) begin
      e_freq = pat;
      e_slow = frame_q[NB+1];
      e_fast = frame_q[NB+2];
    end else begin
      ctrl    = frame_q[NB+1];
      e_out   = pat;
      e_sel   = 4'(ctrl / 16);
      e_mode  = ((ctrl / 4) % 2) == 1;
      e_stop  = ((ctrl / 2) % 2) == 1;
      e_start = (ctrl % 2) == 1;
    end
  endtask

  function automatic logic [7:0] rnd_byte();
    return 8'($urandom_range(0, 255));
  endfunction

  function automatic logic [7:0] garbage_byte();
    logic [7:0] b;
    b = rnd_byte();
    while (b == 8'h0A || b == 8'h0B) b = rnd_byte();
    return b;
  endfunction

  task automatic build_frame(input bit is_freq, input bit rand_ctrl, input logic [7:0] ctrl);
    frame_q = {};
    frame_q.push_back(is_freq ? 8'h0A : 8'h0B);
    for (int i = 0; i < NB; i++) frame_q.push_back(rnd_byte());
    if (is_freq) begin
      frame_q.push_back(rnd_byte());
      frame_q.push_back(rnd_byte());
    end else begin
      frame_q.push_back(rand_ctrl ? rnd_byte() : ctrl);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk_i);
    data_i = b;
    rx_done_tick_i = 1'b1;
    @(negedge clk_i);
    rx_done_tick_i = 1'b0;
    last_strobe_cyc = cyc;
    repeat (gap) @(negedge clk_i);
  endtask

  task automatic drive_frame(input int gmax, output bit mid_changed);
    logic [94:0] snap;
    snap = obs();
    mid_changed = 0;
    for (int i = 0; i < frame_q.size(); i++) begin
      send_byte(frame_q[i], $urandom_range(0, gmax));
      if (i != frame_q.size() - 1 && obs() !== snap) mid_changed = 1;
    end
    repeat (3) @(negedge clk_i);
  endtask

  task automatic test_reset();
    bit mc;
    repeat (3) @(negedge clk_i);
    checks++;
    if (obs() !== 95'd0 || done_tick_o !== 1'b0) begin
      errors++; $display("FAIL reset_hold: got %h/%b required 0/0", obs(), done_tick_o);
    end
    rst_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (obs() !== 95'd0) begin
      errors++; $display("FAIL reset_release: got %h required 0", obs());
    end
    model_clear();
    build_frame(0, 0, 8'hF7);
    drive_frame(2, mc);
    model_apply();
    checks++;
    if (obs() !== expv()) begin
      errors++; $display("FAIL reset_preload: got %h required %h", obs(), expv());
    end
    @(posedge clk_i);
    #3 rst_i = 1'b1;
    #1;
    checks++;
    if (obs() !== 95'd0 || done_tick_o !== 1'b0) begin
      errors++; $display("FAIL reset_async: got %h/%b required 0/0", obs(), done_tick_o);
    end
    model_clear();
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_freq_fixed();
    bit mc;
    int d0;
    frame_q = {8'h0A, 8'h11, 8'h22, 8'h33, 8'h44, 8'h14, 8'h05};
    d0 = done_cnt;
    drive_frame(1, mc);
    model_apply();
    checks++;
    if (obs() !== expv()) begin
      errors++; $display("FAIL freq_fixed: got %h required %h", obs(), expv());
    end
    checks++;
    if (freq_pattern_o !== 32'h44332211 || slow_period_o !== 8'h14 || fast_period_o !== 8'h05
        || cmd_o !== 8'h0A || output_pattern_o !== 32'h0) begin
      errors++; $display("FAIL freq_literal: got %h %h %h %h required 44332211 14 05 0a", freq_pattern_o, slow_period_o, fast_period_o, cmd_o);
    end
    checks++;
    if (done_cnt - d0 !== 1 || done_cyc !== last_strobe_cyc + 1) begin
      errors++; $display("FAIL freq_pulse: got %0d pulses at cycle %0d required 1 at %0d", done_cnt - d0, done_cyc, last_strobe_cyc + 1);
    end
    checks++;
    if (mc !== 1'b0) begin
      errors++; $display("FAIL freq_midframe: got change=%b required 0", mc);
    end
  endtask

  task automatic test_data_fixed();
    bit mc;
    int d0;
    frame_q = {8'h0B, 8'h55, 8'h55, 8'h55, 8'h55, 8'h01};
    d0 = done_cnt;
    drive_frame(0, mc);
    model_apply();
    checks++;
    if (obs() !== expv() || output_pattern_o !== 32'h55555555 || start_o !== 1'b1
        || stop_o !== 1'b0 || mode_o !== 1'b0 || sel_out_o !== 4'd0 || cmd_o !== 8'h0B
        || freq_pattern_o !== 32'h44332211) begin
      errors++; $display("FAIL data_fixed: got %h required %h", obs(), expv());
    end
    checks++;
    if (done_cnt - d0 !== 1 || done_cyc !== last_strobe_cyc + 1 || mc !== 1'b0) begin
      errors++; $display("FAIL data_pulse: got %0d pulses at %0d mid=%b required 1 at %0d mid=0", done_cnt - d0, done_cyc, mc, last_strobe_cyc + 1);
    end
    build_frame(0, 0, 8'h36);
    drive_frame(3, mc);
    model_apply();
    checks++;
    if (obs() !== expv() || sel_out_o !== 4'd3 || mode_o !== 1'b1 || stop_o !== 1'b1
        || start_o !== 1'b0) begin
      errors++; $display("FAIL data_ctrl36: got %h required %h", obs(), expv());
    end
  endtask

  task automatic test_garbage();
    bit mc;
    int d0;
    logic [94:0] snap;
    d0 = done_cnt;
    snap = obs();
    send_byte(8'h7F, 2);
    checks++;
    if (obs() !== snap || done_cnt !== d0) begin
      errors++; $display("FAIL garbage_ignored: got %h/%0d required %h/%0d", obs(), done_cnt, snap, d0);
    end
    build_frame(1, 0, 8'h00);
    drive_frame(2, mc);
    model_apply();
    checks++;
    if (obs() !== expv()) begin
      errors++; $display("FAIL garbage_frame: got %h required %h", obs(), expv());
    end
    checks++;
    if (done_cnt - d0 !== 1 || done_cyc !== last_strobe_cyc + 1) begin
      errors++; $display("FAIL garbage_pulse: got %0d pulses at %0d required 1 at %0d", done_cnt - d0, done_cyc, last_strobe_cyc + 1);
    end
  endtask

  task automatic test_abort();
    bit mc;
    int d0;
    d0 = done_cnt;
    build_frame(0, 1, 8'h00);
    for (int i = 0; i < 4; i++) send_byte(frame_q[i], 1);
    @(negedge clk_i) rst_i = 1'b1;
    @(negedge clk_i) rst_i = 1'b0;
    model_clear();
    checks++;
    if (done_cnt !== d0 || obs() !== 95'd0) begin
      errors++; $display("FAIL abort_discard: got %0d pulses obs %h required 0 pulses obs 0", done_cnt - d0, obs());
    end
    build_frame(0, 1, 8'h00);
    drive_frame(1, mc);
    model_apply();
    checks++;
    if (obs() !== expv() || done_cnt - d0 !== 1) begin
      errors++; $display("FAIL abort_new_frame: got %h/%0d required %h/1", obs(), done_cnt - d0, expv());
    end
  endtask

  task automatic test_random();
    bit mc;
    int d0;
    for (int n = 0; n < 16; n++) begin
      d0 = done_cnt;
      repeat ($urandom_range(0, 2)) send_byte(garbage_byte(), $urandom_range(0, 2));
      build_frame($urandom_range(0, 1) == 1, 1, 8'h00);
      drive_frame(3, mc);
      model_apply();
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL random_frame[%0d]: got %h required %h", n, obs(), expv());
      end
      checks++;
      if (done_cnt - d0 !== 1 || done_cyc !== last_strobe_cyc + 1 || mc !== 1'b0) begin
        errors++; $display("FAIL random_pulse[%0d]: got %0d pulses at %0d mid=%b required 1 at %0d mid=0", n, done_cnt - d0, done_cyc, mc, last_strobe_cyc + 1);
      end
    end
  endtask

  initial begin
    rst_i = 1'b1;
    data_i = 8'h00;
    rx_done_tick_i = 1'b0;
    model_clear();
    test_reset();
    test_freq_fixed();
    test_data_fixed();
    test_garbage();
    test_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
Byte-stream command decoder between a UART receiver and the multi-frequency serial-output channels. Collects command frames from received UART bytes and assembles them into wide registers: output data pattern with channel control, or frequency pattern with slow/fast periods. Publishes each frame atomically with a one-cycle done pulse.

Parameters:
DATA_BIT, 32, width of output and frequency patterns; must be a multiple of 8; NB = DATA_BIT/8 bytes.
PACK_NUM, 5, payload bytes in a data frame: NB pattern bytes plus 1 control byte.
FREQ_NUM, 6, payload bytes in a frequency frame: NB pattern bytes plus slow and fast period bytes.

Ports:
clk_i  in  1  system clock; all logic on the rising edge.
rst_i  in  1  reset, asynchronous, active-high.
data_i  in  8  received UART byte; valid only when rx_done_tick_i=1.
rx_done_tick_i  in  1  one-cycle strobe: data_i holds a new byte.
output_pattern_o  out  DATA_BIT  latched data pattern.
freq_pattern_o  out  DATA_BIT  latched frequency-select pattern.
sel_out_o  out  4  target channel, from control byte [7:4].
mode_o  out  1  0 = one-shot, 1 = repeat; control byte [2].
start_o  out  1  control byte [0].
stop_o  out  1  control byte [1].
slow_period_o  out  8  slow-clock period.
fast_period_o  out  8  fast-clock period.
cmd_o  out  8  command byte of the last completed frame.
done_tick_o  out  1  one-cycle pulse when a frame is published.

Behaviour:
- Reset: all outputs 0. FSM goes to IDLE. Byte counter and shadow buffer are cleared. Reset asserted mid-frame discards the partial frame.
- Command codes: 0x0A = FREQ frame; 0x0B = DATA frame.
- FSM states: IDLE, DATA, FREQ, DONE.
- IDLE:
  - On a byte strobe with 0x0B: go to DATA. With 0x0A: go to FREQ.
  - In both cases, clear the counter and store the command in a shadow register.
  - Any other byte is ignored; the FSM stays in IDLE.
- DATA:
  - Each strobe stores byte k (k = 0..PACK_NUM-1) in the shadow buffer.
  - Bytes 0..NB-1 are pattern bytes, little-endian: byte 0 goes to bits [7:0], byte NB-1 to the top byte.
  - Byte NB is the control byte.
  - After byte PACK_NUM-1, go to DONE.
- FREQ:
  - Bytes 0..NB-1 are freq pattern bytes, little-endian.
  - Byte NB is slow_period; byte NB+1 is fast_period.
  - After byte FREQ_NUM-1, go to DONE.
- DONE, for exactly one cycle:
  - done_tick_o=1 and cmd_o is loaded.
  - DATA frame loads output_pattern_o, sel_out_o, mode_o, stop_o, start_o. Control byte bit3 is reserved and ignored.
  - FREQ frame loads freq_pattern_o, slow_period_o, fast_period_o.
  - Then return to IDLE.
- Latency: outputs change and done_tick_o rises on the first clock edge after the edge that sampled the final byte strobe. No output changes mid-frame.
- Fields not belonging to the completed frame type keep their previous values.
- A byte strobe arriving in the DONE cycle is dropped. The upstream UART guarantees at least one bit time between strobes.
- Outputs are levels held until the next frame of the same type; only done_tick_o is a pulse.
- No timeout. A stalled frame waits indefinitely until completed or reset.

Test Plan:
- Reset: assert rst_i mid-cycle -> all outputs 0 immediately, done_tick_o=0.
- FREQ frame: bytes 0A,11,22,33,44,14,05 -> one done pulse; freq_pattern_o=0x44332211, slow_period_o=0x14, fast_period_o=0x05, cmd_o=0x0A; data fields remain 0.
- DATA frame after the FREQ frame: bytes 0B,55,55,55,55,01 -> output_pattern_o=0x55555555, sel_out_o=0, mode_o=0, start_o=1, stop_o=0, cmd_o=0x0B; freq fields unchanged.
- DATA frame with control 0x36 -> sel_out_o=3, mode_o=1, stop_o=1, start_o=0.
- Garbage byte 0x7F, then a valid FREQ frame -> 0x7F is ignored; exactly one done pulse, after the 7th byte.
- Reset after 3 payload bytes of a DATA frame, then a full DATA frame -> outputs reflect only the new frame; no done pulse for the aborted one.
